pla_sweep_ctrl: RTL
===================

PLA_SWEEP_CTRL -- requirements
Module: pla_sweep_ctrl

Interface
REQ-001 Parameter N_IN, default 15, is the width of the input vector driven to the functions under test.
REQ-002 Parameter CNT_W, default N_IN+1, is the width of the on-set and mismatch counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 abort  input  1  terminate the current sweep; honoured only in RUN.
REQ-007 hold  input  1  freeze the sweep for the cycle; honoured only in RUN.
REQ-008 start_vec  input  N_IN  first vector of the sweep, sampled on the accepted start.
REQ-009 end_vec  input  N_IN  last vector of the sweep (inclusive), sampled on the accepted start.
REQ-010 x  output  N_IN  registered vector driven to both combinational functions.
REQ-011 y_ref  input  1  output of the original (reference) netlist for the current x.
REQ-012 y_dut  input  1  output of the optimized netlist for the current x.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse on sweep completion or abort.
REQ-015 aborted  output  1  high if the last sweep ended by abort; held until the next accepted start.
REQ-016 onset_cnt  output  CNT_W  count of evaluated vectors with y_ref=1.
REQ-017 mism_cnt  output  CNT_W  count of evaluated vectors with y_ref!=y_dut.
REQ-018 first_mism  output  N_IN  vector of the first mismatch; valid when mism_cnt!=0.
REQ-019 signature  output  16  MISR signature over the y_ref stream.

Function
REQ-020 States are IDLE, RUN and DONE; reset enters IDLE.
REQ-021 IDLE with start=1 loads x<=start_vec, latches end_vec, clears the counters and aborted, seeds the MISR with 16'hFFFF, and moves to RUN.
REQ-022 RUN with hold=0 and abort=0 evaluates the current x: it samples y_ref/y_dut, updates the counters, first_mism and the MISR, and does one of two things: if x==latched end, it moves to DONE; otherwise it sets x<=(x+1) mod 2^N_IN.
REQ-023 The sweep wraps from 2^N_IN-1 to 0; a sweep evaluates exactly ((end-start) mod 2^N_IN)+1 vectors, and start==end evaluates one vector.
REQ-024 A full sweep (start=0, end=2^N_IN-1) occupies RUN for exactly 2^N_IN evaluating cycles.
REQ-025 RUN with hold=1 and abort=0 evaluates nothing; x, the counters and the MISR are unchanged.
REQ-026 abort=1 in RUN takes priority over hold and evaluation: the current x is not evaluated, aborted<=1 is set, and the state moves to DONE.
REQ-027 DONE asserts done for one cycle and returns to IDLE; the results are held until the next accepted start.
REQ-028 start outside IDLE is ignored, and abort or hold outside RUN is ignored.
REQ-029 first_mism captures x only on the evaluation that takes mism_cnt from 0 to 1.
REQ-030 The counters saturate at 2^CNT_W-1.
REQ-031 The MISR uses a Galois-form polynomial x^16+x^12+x^3+x+1: each evaluation shifts left, XORs in the polynomial when the MSB was 1, and XORs y_ref into bit 0.
REQ-032 x is constant between evaluations; y_ref and y_dut are sampled in the same cycle that x is presented.

Reset
REQ-033 Reset asserted gives state=IDLE, x=0, busy=0, done=0, aborted=0, onset_cnt=0, mism_cnt=0, first_mism=0 and signature=16'hFFFF, regardless of the operation in progress.
REQ-034 Reset asserted mid-sweep produces no done pulse; after release the block accepts start normally.

Structure
REQ-035 A shared package pla_sweep_pkg holds the state enum, the MISR polynomial constant 16'h100B, the seed 16'hFFFF and the default N_IN.
REQ-036 The MISR is a sub-module pla_sweep_misr with ports clk, rst_n, init, en, din and sig.

Verification
REQ-037 Apply y_ref=y_dut=x[0] with start=0 and end=7FFF: the bench requires onset_cnt=16384, mism_cnt=0, done exactly 32768 cycles after RUN entry, and aborted=0.
REQ-038 Apply y_dut=y_ref except y_dut inverted at x=1234h and x=2000h over a full sweep: the bench requires mism_cnt=2 and first_mism=1234h.
REQ-039 Sweep with start=7FFE and end=0001: the bench requires exactly 4 evaluations (7FFE, 7FFF, 0000, 0001) and x=0001 at the last evaluation.
REQ-040 Assert hold for 10 cycles mid-sweep: the bench requires counters identical to an unheld run, with done delayed by exactly 10 cycles.
REQ-041 Assert abort at x=0100 with start=0: the bench requires 256 evaluations counted, one done pulse, aborted=1, and start ignored while busy.
REQ-042 Assert rst_n low mid-sweep: the bench requires all outputs at their reset values immediately with no done pulse, and a subsequent full sweep matching REQ-037 including an identical signature.

Source files
------------

// File: rtl/pla_sweep_pkg.sv
// pla_sweep_pkg: shared types and constants for the PLA equivalence sweep controller
//   state_t    : controller state encoding (IDLE, RUN, DONE)
//   MISR_POLY  : Galois feedback taps for x^16+x^12+x^3+x+1
//   MISR_SEED  : MISR value after reset and at the start of every sweep
//   N_IN_DEF   : default width of the swept input vector
package pla_sweep_pkg;

    localparam int          N_IN_DEF  = 15;
    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pla_sweep_if.sv
// pla_sweep_if: sweep control, function-under-test and result signals
//   i_start/i_abort/i_hold         : sweep commands into the controller
//   i_start_vec/i_end_vec          : inclusive sweep range, sampled on start
//   o_x, i_y_ref, i_y_dut          : vector to both netlists and their outputs
//   o_busy/o_done/o_aborted        : sweep status
//   o_onset_cnt/o_mism_cnt         : saturating result counters
//   o_first_mism/o_signature       : first failing vector and y_ref MISR
//   master : stimulus side (drives commands and netlist outputs)
//   slave  : controller side
interface pla_sweep_if
    import pla_sweep_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = N_IN + 1
);

    logic             i_start;
    logic             i_abort;
    logic             i_hold;
    logic [N_IN-1:0]  i_start_vec;
    logic [N_IN-1:0]  i_end_vec;
    logic [N_IN-1:0]  o_x;
    logic             i_y_ref;
    logic             i_y_dut;
    logic             o_busy;
    logic             o_done;
    logic             o_aborted;
    logic [CNT_W-1:0] o_onset_cnt;
    logic [CNT_W-1:0] o_mism_cnt;
    logic [N_IN-1:0]  o_first_mism;
    logic [15:0]      o_signature;

    modport master (
        output i_start, i_abort, i_hold, i_start_vec, i_end_vec, i_y_ref, i_y_dut,
        input  o_x, o_busy, o_done, o_aborted, o_onset_cnt, o_mism_cnt,
               o_first_mism, o_signature
    );

    modport slave (
        input  i_start, i_abort, i_hold, i_start_vec, i_end_vec, i_y_ref, i_y_dut,
        output o_x, o_busy, o_done, o_aborted, o_onset_cnt, o_mism_cnt,
               o_first_mism, o_signature
    );

endinterface

// File: rtl/pla_sweep_misr.sv
// pla_sweep_misr: 16-bit single-input Galois MISR compacting the reference output stream
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads the seed
//   init  : reload the seed (takes priority over en)
//   en    : absorb din this cycle
//   din   : serial input bit
//   sig   : current signature
module pla_sweep_misr
    import pla_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] r_sig;
    logic [15:0] w_step;

    // Shift left, fold the taps back in when the MSB falls out, inject din at bit 0
    assign w_step = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000) ^ {15'd0, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sig <= MISR_SEED;
        else if (init)
            r_sig <= MISR_SEED;
        else if (en)
            r_sig <= w_step;
    end

    assign sig = r_sig;

endmodule

// File: rtl/pla_sweep_ctrl.sv
// pla_sweep_ctrl: sweeps an input range through reference and optimized netlists and compares them
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pla_sweep_if slave modport (commands, vector out, netlist outputs, results)
// One vector is evaluated per RUN cycle unless held or aborted; the range is inclusive
// and wraps modulo 2^N_IN. Results persist from completion until the next accepted start.
module pla_sweep_ctrl
    import pla_sweep_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = N_IN + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    pla_sweep_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [N_IN-1:0]  X_ONE   = N_IN'(1);

    state_t           r_state;
    state_t           w_next;
    logic [N_IN-1:0]  r_x;
    logic [N_IN-1:0]  r_end;
    logic [N_IN-1:0]  r_first;
    logic [CNT_W-1:0] r_onset;
    logic [CNT_W-1:0] r_mism;
    logic             r_aborted;
    logic             w_accept;
    logic             w_abort;
    logic             w_eval;
    logic             w_last;
    logic             w_mism;
    logic [15:0]      w_sig;

    always_comb begin
        w_accept = (r_state == S_IDLE) && bus.i_start;
        w_abort  = (r_state == S_RUN) && bus.i_abort;
        // Abort outranks hold, and both suppress evaluation
        w_eval   = (r_state == S_RUN) && !bus.i_abort && !bus.i_hold;
        w_last   = (r_x == r_end);
        w_mism   = bus.i_y_ref != bus.i_y_dut;
        w_next   = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.i_start ? S_RUN : S_IDLE;
            S_RUN:   w_next = (w_abort || (w_eval && w_last)) ? S_DONE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_end     <= '0;
            r_first   <= '0;
            r_onset   <= '0;
            r_mism    <= '0;
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_x       <= bus.i_start_vec;
            r_end     <= bus.i_end_vec;
            r_first   <= '0;
            r_onset   <= '0;
            r_mism    <= '0;
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_aborted <= 1'b1;
        end else if (w_eval) begin
            // x stays on the end vector so it still shows the last evaluation
            if (!w_last)
                r_x <= r_x + X_ONE;
            if (bus.i_y_ref && r_onset != CNT_MAX)
                r_onset <= r_onset + CNT_ONE;
            if (w_mism && r_mism != CNT_MAX)
                r_mism <= r_mism + CNT_ONE;
            if (w_mism && r_mism == '0)
                r_first <= r_x;
        end
    end

    pla_sweep_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_accept),
        .en    (w_eval),
        .din   (bus.i_y_ref),
        .sig   (w_sig)
    );

    assign bus.o_x          = r_x;
    assign bus.o_busy       = (r_state == S_RUN);
    assign bus.o_done       = (r_state == S_DONE);
    assign bus.o_aborted    = r_aborted;
    assign bus.o_onset_cnt  = r_onset;
    assign bus.o_mism_cnt   = r_mism;
    assign bus.o_first_mism = r_first;
    assign bus.o_signature  = w_sig;

endmodule
